// File: rtl/alu_issue_ctrl_if.sv
// Bus bundle for alu_issue_ctrl: command input, ALU issue/return path and result output.
interface alu_issue_ctrl_if;
  // Upstream command handshake
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_opc;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [1:0] cmd_seld;
  // ALU issue and return
  logic       alu_enable;
  logic [7:0] alu_opc;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [1:0] alu_seld;
  logic [7:0] alu_z;
  logic       alu_done;
  // Downstream result handshake
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic [7:0] res_opc;
  logic       res_err;
  // Status
  logic [4:0] fifo_count;

  // Controller side
  modport slave (
    input  cmd_valid, cmd_opc, cmd_a, cmd_b, cmd_seld, alu_z, alu_done, res_ready,
    output cmd_ready, alu_enable, alu_opc, alu_a, alu_b, alu_seld,
           res_valid, res_data, res_opc, res_err, fifo_count
  );

  // Environment side (command source, ALU, result sink)
  modport master (
    output cmd_valid, cmd_opc, cmd_a, cmd_b, cmd_seld, alu_z, alu_done, res_ready,
    input  cmd_ready, alu_enable, alu_opc, alu_a, alu_b, alu_seld,
           res_valid, res_data, res_opc, res_err, fifo_count
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: buffers commands in a small FIFO, issues them one at a
// time to the ALU, waits for single- or multi-cycle completion (with timeout)
// and presents each result on a valid/ready port.
module alu_issue_ctrl #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic            clock,
  input  logic            reset,
  alu_issue_ctrl_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic [7:0] opc;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] seld;
  } cmd_t;

  state_t        state, state_nxt;
  cmd_t          mem [DEPTH];
  cmd_t          cmd_in, head, alu_q;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [4:0]    count;
  logic [7:0]    tmo_cnt;
  logic [7:0]    res_data_q, res_opc_q;
  logic          res_err_q;
  logic          push, pop, head_legal, multi, wait_done, wait_tmo;
  logic          alu_enable_c, res_valid_c;

  assign cmd_in     = '{opc: bus.cmd_opc, a: bus.cmd_a, b: bus.cmd_b, seld: bus.cmd_seld};
  assign head       = mem[rd_ptr];
  assign head_legal = (head.opc <= 8'h07);

  // Ready only reflects occupancy: a pop in the same cycle never frees a slot early.
  assign bus.cmd_ready = !reset && (count < 5'(DEPTH));
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign pop           = (state == IDLE) && (count != 5'd0);

  // Opcode 0x00 waits for alu_done; everything else completes on the first WAIT cycle.
  assign multi     = (alu_q.opc == 8'h00);
  assign wait_done = multi ? bus.alu_done : 1'b1;
  assign wait_tmo  = multi && !bus.alu_done && (tmo_cnt == 8'(TIMEOUT - 1));

  // FIFO storage write
  // NOTE: the storage array is not reset; pointers and count define which entries are live.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= cmd_in;
  end

  // FIFO pointers and occupancy
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + 5'(push) - 5'(pop);
    end
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    // NOTE: default assignment first so every path drives state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE:    if (pop) state_nxt = head_legal ? ISSUE : RESP;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (wait_done || wait_tmo) state_nxt = RESP;
      RESP:    if (bus.res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    alu_enable_c = 1'b0;
    res_valid_c  = 1'b0;
    case (state)
      ISSUE:   alu_enable_c = 1'b1;
      RESP:    res_valid_c  = 1'b1;
      default: ;
    endcase
  end

  // Datapath: ALU operand latch, timeout counter and result capture
  always_ff @(posedge clock) begin
    if (reset) begin
      alu_q      <= '0;
      tmo_cnt    <= '0;
      res_data_q <= '0;
      res_opc_q  <= '0;
      res_err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            alu_q <= head;
            if (!head_legal) begin
              res_data_q <= 8'h00;
              res_opc_q  <= head.opc;
              res_err_q  <= 1'b1;
            end
          end
        end
        ISSUE: tmo_cnt <= '0;
        WAIT: begin
          if (wait_done) begin
            res_data_q <= bus.alu_z;
            res_opc_q  <= alu_q.opc;
            res_err_q  <= 1'b0;
          end else if (wait_tmo) begin
            res_data_q <= 8'hFF;
            res_opc_q  <= alu_q.opc;
            res_err_q  <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.alu_enable = alu_enable_c;
  assign bus.alu_opc    = alu_q.opc;
  assign bus.alu_a      = alu_q.a;
  assign bus.alu_b      = alu_q.b;
  assign bus.alu_seld   = alu_q.seld;
  assign bus.res_valid  = res_valid_c;
  assign bus.res_data   = res_data_q;
  assign bus.res_opc    = res_opc_q;
  assign bus.res_err    = res_err_q;
  assign bus.fifo_count = count;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed scenarios followed by a
// randomized phase scored against a transaction-level result model.
module tb_alu_issue_ctrl;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 15;

  logic clock = 1'b0;
  logic reset = 1'b1;

  alu_issue_ctrl_if bus ();

  alu_issue_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] opc;
    logic [7:0] data;
    logic       err;
  } res_t;

  res_t exp_q [$];   // expected results in issue order
  int   plan_q [$];  // alu_done WAIT-cycle index per multicycle command (0 = never)
  int   passed  = 0;
  int   total   = 0;
  int   failed  = 0;
  int   max_cnt = 0;

  // Behavioural ALU used both to answer the DUT and to predict results.
  function automatic logic [7:0] alu_fn(input logic [7:0] opc, a, b, input logic [1:0] seld);
    logic [15:0] prod;
    prod = a * b;
    case (opc)
      8'h00:   return prod[7:0];
      8'h01:   return a - b;
      8'h02:   return a + b;
      8'h03:   return a & b;
      8'h04:   return a | b;
      8'h05:   return a ^ b;
      8'h06:   return ~a;
      8'h07:   return a >> seld;
      default: return 8'h00;
    endcase
  endfunction

  assign bus.alu_z = alu_fn(bus.alu_opc, bus.alu_a, bus.alu_b, bus.alu_seld);

  // Result predicted from the command alone and the planned alu_done timing.
  function automatic res_t predict(input logic [7:0] opc, a, b, input logic [1:0] seld, input int d);
    res_t r;
    r.opc = opc;
    if (opc > 8'h07) begin
      r.data = 8'h00; r.err = 1'b1;
    end else if (opc == 8'h00 && !(d >= 1 && d <= TIMEOUT)) begin
      r.data = 8'hFF; r.err = 1'b1;
    end else begin
      r.data = alu_fn(opc, a, b, seld); r.err = 1'b0;
    end
    return r;
  endfunction

  // ALU completion responder: follows each multicycle issue and raises alu_done
  // on the planned WAIT cycle; outside that window it toggles randomly.
  int wait_k, target;
  bit active;
  always @(posedge clock) begin
    #2;
    if (reset) begin
      active = 1'b0;
      bus.alu_done = 1'b0;
    end else if (bus.alu_enable) begin
      active = (bus.alu_opc == 8'h00);
      target = 0;
      if (active && plan_q.size() > 0) target = plan_q.pop_front();
      wait_k = 0;
      bus.alu_done = 1'($urandom_range(0, 1));
    end else if (active) begin
      wait_k++;
      bus.alu_done = (target != 0 && wait_k == target);
      if (wait_k >= TIMEOUT || (target != 0 && wait_k >= target)) active = 1'b0;
    end else begin
      bus.alu_done = 1'($urandom_range(0, 1));
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    if (int'(bus.fifo_count) > max_cnt) max_cnt = int'(bus.fifo_count);
  endtask

  // Present one command until accepted; returns in the cycle after acceptance.
  task automatic push_cmd(input logic [7:0] opc, a, b, input logic [1:0] seld, input int d);
    bit acc;
    acc = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_opc = opc; bus.cmd_a = a; bus.cmd_b = b; bus.cmd_seld = seld;
    for (int i = 0; i < 64 && !acc; i++) begin
      acc = bus.cmd_ready;
      step();
    end
    bus.cmd_valid = 1'b0;
    check("push_accept", 32'(acc), 32'd1);
    if (acc) begin
      exp_q.push_back(predict(opc, a, b, seld, d));
      if (opc == 8'h00) plan_q.push_back(d);
    end
  endtask

  // Compare the result currently on the port against the model's next entry.
  task automatic check_result(input string tag);
    res_t e;
    check({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_res_opc"},  bus.res_opc,  e.opc);
      check({tag, "_res_data"}, bus.res_data, e.data);
      check({tag, "_res_err"},  bus.res_err,  e.err);
    end
  endtask

  // Count cycles until res_valid, noting any issue strobe on the way.
  task automatic wait_res(output int lat, output bit saw_en);
    lat = 0; saw_en = 1'b0;
    while (!bus.res_valid && lat < 100) begin
      step();
      lat++;
      if (bus.alu_enable) saw_en = 1'b1;
    end
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    while (exp_q.size() != 0 && guard < 2000) begin
      if (bus.res_valid) check_result(tag);
      step();
      guard++;
    end
    check({tag, "_drained"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    int         lat, r, d;
    bit         saw_en, acc, moved, pulsed, seen_valid;
    logic [7:0] opc, a, b;
    logic [1:0] seld;

    bus.cmd_valid = 1'b0; bus.cmd_opc = '0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_seld = '0;
    bus.res_ready = 1'b0;

    // Reset state
    reset = 1'b1;
    step(); step();
    check("rst_cmd_ready",  bus.cmd_ready,  0);
    check("rst_fifo_count", bus.fifo_count, 0);
    check("rst_res_valid",  bus.res_valid,  0);
    check("rst_alu_enable", bus.alu_enable, 0);
    check("rst_alu_opc",    bus.alu_opc,    0);
    check("rst_res_err",    bus.res_err,    0);
    reset = 1'b0;
    step();
    check("rst_release_ready", bus.cmd_ready, 1);

    // Single-cycle subtract: 0x09 - 0x04, result three cycles after the pop cycle
    bus.res_ready = 1'b1;
    push_cmd(8'h01, 8'h09, 8'h04, 2'd0, 0);
    check("t1_count_pushed", bus.fifo_count, 1);
    step();
    check("t1_issue_strobe", bus.alu_enable, 1);
    check("t1_alu_opc",      bus.alu_opc,    8'h01);
    check("t1_alu_a",        bus.alu_a,      8'h09);
    check("t1_alu_b",        bus.alu_b,      8'h04);
    check("t1_count_popped", bus.fifo_count, 0);
    wait_res(lat, saw_en);
    check("t1_latency",  32'(lat + 1), 3);
    check("t1_res_data", bus.res_data, 8'h05);
    check_result("t1");
    step();
    check("t1_valid_drop", bus.res_valid, 0);

    // Illegal opcode: no issue strobe, error result with zero data
    push_cmd(8'h09, 8'h33, 8'h44, 2'd1, 0);
    wait_res(lat, saw_en);
    check("t2_no_enable", 32'(saw_en), 0);
    check("t2_res_err",   bus.res_err,  1);
    check("t2_res_data",  bus.res_data, 8'h00);
    check("t2_res_opc",   bus.res_opc,  8'h09);
    check_result("t2");
    step();

    // Multicycle opcode: timeout, done on the last allowed cycle, early done
    push_cmd(8'h00, 8'h07, 8'h06, 2'd0, 0);
    wait_res(lat, saw_en);
    check("t3_tmo_latency", lat, 32'(TIMEOUT + 2));
    check("t3_tmo_err",  bus.res_err,  1);
    check("t3_tmo_data", bus.res_data, 8'hFF);
    check_result("t3_tmo");
    step();
    push_cmd(8'h00, 8'h03, 8'h05, 2'd0, TIMEOUT);
    wait_res(lat, saw_en);
    check("t3_edge_latency", lat, 32'(TIMEOUT + 2));
    check("t3_edge_err",  bus.res_err,  0);
    check("t3_edge_data", bus.res_data, 8'h0F);
    check_result("t3_edge");
    step();
    push_cmd(8'h00, 8'h11, 8'h10, 2'd0, 3);
    wait_res(lat, saw_en);
    check("t3_early_latency", lat, 5);
    check_result("t3_early");
    step();

    // Back-pressure: result held in RESP, FIFO fills, fifth command waits for a pop
    bus.res_ready = 1'b0;
    push_cmd(8'h02, 8'h10, 8'h20, 2'd1, 0);
    wait_res(lat, saw_en);
    check("t4_first_valid", bus.res_valid, 1);
    for (int i = 0; i < 4; i++) push_cmd(8'(i + 1), 8'(i * 7 + 1), 8'(i + 2), 2'(i), 0);
    bus.cmd_valid = 1'b1;
    bus.cmd_opc = 8'h05; bus.cmd_a = 8'h0F; bus.cmd_b = 8'hF0; bus.cmd_seld = 2'd3;
    acc = 1'b0; moved = 1'b0; pulsed = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.cmd_ready) acc = 1'b1;
      if (bus.res_data !== 8'h30 || bus.res_opc !== 8'h02 || bus.res_err !== 1'b0 || bus.res_valid !== 1'b1)
        moved = 1'b1;
      if (bus.alu_enable) pulsed = 1'b1;
      step();
    end
    check("t4_fifo_full",   bus.fifo_count, 4);
    check("t4_ready_low",   bus.cmd_ready,  0);
    check("t4_fifth_held",  32'(acc),    0);
    check("t4_res_stable",  32'(moved),  0);
    check("t4_no_reissue",  32'(pulsed), 0);
    check_result("t4_held");
    bus.res_ready = 1'b1;
    step();
    check("t4_no_bypass",     bus.cmd_ready,  0);
    check("t4_count_at_pop",  bus.fifo_count, 4);
    step();
    check("t4_ready_after_pop", bus.cmd_ready,  1);
    check("t4_count_popped",    bus.fifo_count, 3);
    check("t4_next_issue",      bus.alu_enable, 1);
    step();
    bus.cmd_valid = 1'b0;
    exp_q.push_back(predict(8'h05, 8'h0F, 8'hF0, 2'd3, 0));
    check("t4_fifth_accepted", bus.fifo_count, 4);
    drain("t4");

    // Reset while waiting on a multicycle command with two entries queued
    push_cmd(8'h00, 8'h21, 8'h02, 2'd0, 0);
    push_cmd(8'h01, 8'h50, 8'h10, 2'd0, 0);
    push_cmd(8'h02, 8'h01, 8'h01, 2'd0, 0);
    step(); step();
    check("t5_queued", bus.fifo_count, 2);
    reset = 1'b1;
    step();
    exp_q.delete();
    plan_q.delete();
    check("t5_rst_count",  bus.fifo_count, 0);
    check("t5_rst_valid",  bus.res_valid,  0);
    check("t5_rst_opc",    bus.alu_opc,    0);
    check("t5_rst_a",      bus.alu_a,      0);
    check("t5_rst_b",      bus.alu_b,      0);
    check("t5_rst_ready",  bus.cmd_ready,  0);
    reset = 1'b0;
    step();
    check("t5_ready_after_release", bus.cmd_ready, 1);
    seen_valid = 1'b0; pulsed = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (bus.res_valid) seen_valid = 1'b1;
      if (bus.alu_enable) pulsed = 1'b1;
      step();
    end
    check("t5_no_res_valid", 32'(seen_valid), 0);
    check("t5_no_issue",     32'(pulsed),     0);
    check("t5_count_empty",  bus.fifo_count,  0);

    // Randomized traffic against the result model
    for (int cyc = 0; cyc < 400; cyc++) begin
      r    = $urandom_range(0, 9);
      opc  = (r < 8) ? 8'(r) : 8'($urandom_range(8, 255));
      a    = 8'($urandom);
      b    = 8'($urandom);
      seld = 2'($urandom);
      d    = (opc == 8'h00) ? $urandom_range(0, 18) : 0;
      bus.cmd_valid = ($urandom_range(0, 99) < 55);
      bus.cmd_opc = opc; bus.cmd_a = a; bus.cmd_b = b; bus.cmd_seld = seld;
      bus.res_ready = ($urandom_range(0, 99) < 70);
      if (bus.cmd_valid && bus.cmd_ready) begin
        exp_q.push_back(predict(opc, a, b, seld, d));
        if (opc == 8'h00) plan_q.push_back(d);
      end
      if (bus.res_valid && bus.res_ready) check_result("rnd");
      step();
    end
    drain("rnd");

    check("max_fifo_count", max_cnt, DEPTH);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
